alu32_mc: RTL and testbench

Multi-cycle, handshake-driven 32-bit ALU that services operation requests from an upstream issuer, such as a sequencer or the datapath controller. It uses the same 4-bit `aluctr` encodings as the combinational `ALU32`. Shifts run serially at one bit per cycle to save area; all other operations complete in a single compute cycle. Results are returned through a valid/ready response port and held until they are consumed.

---
 rtl/alu32_mc.sv | 152 +++++++++++++++
 tb/tb_alu32_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_mc.sv
// alu32_mc: multi-cycle 32-bit ALU behind a valid/ready request/response
// handshake. Opcodes match the combinational ALU32 aluctr encoding.
// Shifts execute serially, one bit per cycle. Everything else completes
// in a single compute cycle. The response is held until consumed.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  request handshake (in_ready high only in IDLE)
//   aluctr, dataa,     opcode and operands, sampled on accept
//   datab
//   out_valid/out_ready response handshake
//   result, zero,      registered result, result==0 flag, and
//   out_err            unsupported-opcode flag
module alu32_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   aluctr,
    input  logic [N-1:0] dataa,
    input  logic [N-1:0] datab,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         out_err
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t       state;
    logic [3:0]   op_r;
    logic [N-1:0] work;
    logic [4:0]   cnt;

    logic         is_shift;
    logic [4:0]   sh;
    logic [N-1:0] calc_res;
    logic         calc_err;
    logic [N-1:0] work_next;

    assign sh       = datab[4:0];
    assign is_shift = (aluctr == OP_SLL) || (aluctr == OP_SRL) || (aluctr == OP_SRA);

    // Single-cycle results. A shift only reaches this path when sh==0,
    // so its result is simply operand A (no barrel shifter needed).
    always_comb begin
        calc_res = '0;
        calc_err = 1'b0;
        case (aluctr)
            OP_ADD:  calc_res = dataa + datab;
            OP_SUB:  calc_res = dataa - datab;
            OP_SLT:  calc_res = {{(N-1){1'b0}}, ($signed(dataa) < $signed(datab))};
            OP_SLTU: calc_res = {{(N-1){1'b0}}, (dataa < datab)};
            OP_XOR:  calc_res = dataa ^ datab;
            OP_OR:   calc_res = dataa | datab;
            OP_AND:  calc_res = dataa & datab;
            OP_LUI:  calc_res = datab;
            OP_SLL, OP_SRL, OP_SRA: calc_res = dataa;
            default: begin
                calc_res = '0;
                calc_err = 1'b1;
            end
        endcase
    end

    // One-bit step of the serial shifter, direction/fill chosen by the
    // latched opcode.
    always_comb begin
        case (op_r)
            OP_SLL:  work_next = {work[N-2:0], 1'b0};
            OP_SRL:  work_next = {1'b0, work[N-1:1]};
            default: work_next = {work[N-1], work[N-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            out_err   <= 1'b0;
            op_r      <= '0;
            work      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r     <= aluctr;
                        in_ready <= 1'b0;
                        if (is_shift && (sh != 5'd0)) begin
                            work  <= dataa;
                            cnt   <= sh;
                            state <= S_SHIFT;
                        end else begin
                            result    <= calc_res;
                            zero      <= (calc_res == '0);
                            out_err   <= calc_err;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result    <= work_next;
                        zero      <= (work_next == '0);
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_mc.sv
module tb_alu32_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  aluctr = '0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        out_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    alu32_mc #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctr    (aluctr),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic straight from the opcode table.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
        int unsigned s;
        s = b[4:0];
        e = 1'b0;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a << s;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> s;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1000: r = a - b;
            4'b1101: r = $unsigned($signed(a) >>> s);
            4'b1111: r = b;
            default: begin
                r = 32'd0;
                e = 1'b1;
            end
        endcase
    endfunction

    function automatic int unsigned ref_lat(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && b[4:0] != 5'd0)
            return 1 + int'(b[4:0]);
        return 1;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned bp);
        logic [31:0] er;
        logic        ee;
        int unsigned elat;
        int unsigned lat;
        ref_alu(op, a, b, er, ee);
        elat = ref_lat(op, b);
        check("in_ready_idle", in_ready, 1);
        aluctr   = op;
        dataa    = a;
        datab    = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, elat);
        check("result", result, er);
        check("zero", zero, (er == 32'd0));
        check("out_err", out_err, ee);
        check("in_ready_done", in_ready, 0);
        repeat (bp) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_result", result, er);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consumed", out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;

        // Reset values
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_err", out_err, 0);
        rst_n = 1'b1;

        // out_ready with no response pending does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_valid", out_valid, 0);
        check("idle_ready_in", in_ready, 1);

        // Directed cases
        run_op(4'b0000, 32'h7FFFFFFF, 32'h00000001, 0);
        run_op(4'b1000, 32'h12345678, 32'h12345678, 0);
        run_op(4'b0010, 32'h80000000, 32'h7FFFFFFF, 0);
        run_op(4'b0011, 32'h80000000, 32'h7FFFFFFF, 0);
        run_op(4'b1101, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(4'b0101, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(4'b0001, 32'h00000001, 32'h00000020, 0);
        run_op(4'b0001, 32'h80000001, 32'h00000001, 1);
        run_op(4'b1010, 32'hDEADBEEF, 32'h12345678, 0);
        run_op(4'b0111, 32'hFF00FF00, 32'h0FF00FF0, 0);

        // Backpressure with a new request held during DONE
        aluctr   = 4'b0100;
        dataa    = 32'hF0F0F0F0;
        datab    = 32'hFFFF0000;
        in_valid = 1'b1;
        tick();
        aluctr = 4'b0000;
        dataa  = 32'd5;
        datab  = 32'd6;
        check("bp_valid0", out_valid, 1);
        check("bp_result0", result, 32'h0F0FF0F0);
        check("bp_in_ready0", in_ready, 0);
        repeat (5) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_result", result, 32'h0F0FF0F0);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_consume", out_valid, 0);
        check("bp_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("pend_valid", out_valid, 1);
        check("pend_result", result, 32'd11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during a long shift
        aluctr   = 4'b0001;
        dataa    = 32'h00000123;
        datab    = 32'd20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, 0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("no_resp_after_rst", seen, 0);
        run_op(4'b1111, $urandom, 32'hABCDE000, 0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  op;
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'd0};
            if ($urandom_range(0, 3) == 0) b = a;
            run_op(op, a, b, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
